// File: rtl/clip_sequencer_if.sv
// Clip BRAM port bundle: the sequencer drives the request side (master),
// the memory returns read data one cycle after an enabled read (slave).
interface clip_sequencer_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
);
    logic              mem_en;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_en,
        output mem_wen,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en,
        input  mem_wen,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/clip_sequencer.sv
// Record/playback sequencer: owns NUM_CLIPS fixed regions of one clip BRAM,
// tracks each clip's recorded length and issues one memory access per sample tick.
module clip_sequencer #(
    parameter int NUM_CLIPS  = 2,
    parameter int CLIP_DEPTH = 4096,
    parameter int DATA_W     = 16,
    parameter int SEL_W      = $clog2(NUM_CLIPS),
    parameter int ADDR_W     = $clog2(NUM_CLIPS * CLIP_DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [SEL_W-1:0]  clip_sel_record,
    input  logic [SEL_W-1:0]  clip_sel_play,
    input  logic              record,
    input  logic              play,
    input  logic              loop_en,
    input  logic              sample_tick,
    input  logic [DATA_W-1:0] sample_in,
    clip_sequencer_if.master  mem,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_out_valid,
    output logic              recording,
    output logic              playing,
    output logic [SEL_W-1:0]  active_clip,
    output logic              done
);

    localparam int PTR_W = $clog2(CLIP_DEPTH);
    localparam int LEN_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REC,
        ST_REC_FULL,
        ST_PLAY
    } state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [SEL_W-1:0]    active_clip_q, active_clip_d;
    logic [LEN_W-1:0]    clip_len_q [NUM_CLIPS];
    logic [LEN_W-1:0]    clip_len_d [NUM_CLIPS];
    logic                record_prev_q, record_prev_d;
    logic                play_prev_q, play_prev_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_wen_q, mem_wen_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                rd_last_q, rd_last_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   sample_hold_q, sample_hold_d;
    logic                done_q, done_d;

    logic                rec_edge;
    logic                play_edge;
    logic                op_done;

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        active_clip_d  = active_clip_q;
        clip_len_d     = clip_len_q;
        record_prev_d  = record;
        play_prev_d    = play;
        mem_en_d       = 1'b0;
        mem_wen_d      = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        rd_last_d      = 1'b0;
        op_done        = 1'b0;
        rec_edge       = record & ~record_prev_q;
        play_edge      = play & ~play_prev_q;

        case (state_q)
            ST_IDLE: begin
                if (rec_edge) begin
                    state_d       = ST_REC;
                    active_clip_d = clip_sel_record;
                    ptr_d         = '0;
                end else if (play_edge && clip_len_q[clip_sel_play] != '0) begin
                    state_d       = ST_PLAY;
                    active_clip_d = clip_sel_play;
                    ptr_d         = '0;
                end
            end
            ST_REC: begin
                // Release is checked before the tick: a tick in the release cycle is dropped.
                if (!record) begin
                    state_d                   = ST_IDLE;
                    clip_len_d[active_clip_q] = LEN_W'(ptr_q);
                    op_done                   = 1'b1;
                end else if (sample_tick) begin
                    mem_en_d    = 1'b1;
                    mem_wen_d   = 1'b1;
                    mem_addr_d  = {active_clip_q, ptr_q};
                    mem_wdata_d = sample_in;
                    if (ptr_q == '1) begin
                        state_d                   = ST_REC_FULL;
                        clip_len_d[active_clip_q] = LEN_W'(CLIP_DEPTH);
                        op_done                   = 1'b1;
                    end else begin
                        ptr_d = ptr_q + PTR_W'(1);
                    end
                end
            end
            ST_REC_FULL: begin
                if (!record) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (play_edge) begin
                    state_d = ST_IDLE;
                    op_done = 1'b1;
                end else if (sample_tick) begin
                    mem_en_d   = 1'b1;
                    mem_addr_d = {active_clip_q, ptr_q};
                    if (LEN_W'(ptr_q) == clip_len_q[active_clip_q] - LEN_W'(1)) begin
                        if (loop_en) begin
                            ptr_d = '0;
                        end else begin
                            state_d   = ST_IDLE;
                            rd_last_d = 1'b1;
                        end
                    end else begin
                        ptr_d = ptr_q + PTR_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Read data arrives the cycle after mem_en; the end-of-clip done rides along with it.
        out_valid_d   = mem_en_q & ~mem_wen_q;
        sample_hold_d = out_valid_q ? mem.mem_rdata : sample_hold_q;
        done_d        = op_done | rd_last_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            active_clip_q <= '0;
            clip_len_q    <= '{default: '0};
            record_prev_q <= 1'b0;
            play_prev_q   <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_wen_q     <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            rd_last_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            sample_hold_q <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            active_clip_q <= active_clip_d;
            clip_len_q    <= clip_len_d;
            record_prev_q <= record_prev_d;
            play_prev_q   <= play_prev_d;
            mem_en_q      <= mem_en_d;
            mem_wen_q     <= mem_wen_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            rd_last_q     <= rd_last_d;
            out_valid_q   <= out_valid_d;
            sample_hold_q <= sample_hold_d;
            done_q        <= done_d;
        end
    end

    assign mem.mem_en       = mem_en_q;
    assign mem.mem_wen      = mem_wen_q;
    assign mem.mem_addr     = mem_addr_q;
    assign mem.mem_wdata    = mem_wdata_q;
    assign sample_out       = out_valid_q ? mem.mem_rdata : sample_hold_q;
    assign sample_out_valid = out_valid_q;
    assign recording        = (state_q == ST_REC) || (state_q == ST_REC_FULL);
    assign playing          = (state_q == ST_PLAY);
    assign active_clip      = active_clip_q;
    assign done             = done_q;

endmodule

// File: tb/tb_clip_sequencer.sv
// Bench for clip_sequencer: BRAM fixture, event monitor, and a clip-level
// reference model (per-clip sample lists and lengths) driving the expectations.
module tb_clip_sequencer;

    localparam int NUM_CLIPS  = 2;
    localparam int CLIP_DEPTH = 4096;
    localparam int DATA_W     = 16;
    localparam int SEL_W      = 1;
    localparam int ADDR_W     = 13;

    logic              clock = 1'b0;
    logic              reset;
    logic [SEL_W-1:0]  clip_sel_record, clip_sel_play;
    logic              record, play, loop_en, sample_tick;
    logic [DATA_W-1:0] sample_in;
    logic [DATA_W-1:0] sample_out;
    logic              sample_out_valid, recording, playing, done;
    logic [SEL_W-1:0]  active_clip;

    clip_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

    clip_sequencer #(
        .NUM_CLIPS (NUM_CLIPS),
        .CLIP_DEPTH(CLIP_DEPTH),
        .DATA_W    (DATA_W)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .clip_sel_record (clip_sel_record),
        .clip_sel_play   (clip_sel_play),
        .record          (record),
        .play            (play),
        .loop_en         (loop_en),
        .sample_tick     (sample_tick),
        .sample_in       (sample_in),
        .mem             (mem_if),
        .sample_out      (sample_out),
        .sample_out_valid(sample_out_valid),
        .recording       (recording),
        .playing         (playing),
        .active_clip     (active_clip),
        .done            (done)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // BRAM fixture with 1-cycle read latency
    logic [DATA_W-1:0] bram [NUM_CLIPS*CLIP_DEPTH];
    always @(posedge clock) begin
        if (mem_if.mem_en) begin
            if (mem_if.mem_wen) bram[mem_if.mem_addr] <= mem_if.mem_wdata;
            else                mem_if.mem_rdata     <= bram[mem_if.mem_addr];
        end
    end

    // Observed events, sampled mid-cycle
    int unsigned wr_addr_q[$], wr_data_q[$], wr_cyc_q[$];
    int unsigned rd_addr_q[$], rd_cyc_q[$];
    int unsigned out_val_q[$], out_cyc_q[$];
    int unsigned done_cyc_q[$];

    always @(negedge clock) begin
        if (mem_if.mem_en && mem_if.mem_wen) begin
            wr_addr_q.push_back(int'(mem_if.mem_addr));
            wr_data_q.push_back(int'(mem_if.mem_wdata));
            wr_cyc_q.push_back(cyc);
        end
        if (mem_if.mem_en && !mem_if.mem_wen) begin
            rd_addr_q.push_back(int'(mem_if.mem_addr));
            rd_cyc_q.push_back(cyc);
        end
        if (sample_out_valid) begin
            out_val_q.push_back(int'(sample_out));
            out_cyc_q.push_back(cyc);
        end
        if (done) done_cyc_q.push_back(cyc);
    end

    // Reference model: what each clip holds, at the level of recorded samples
    int unsigned model_len [NUM_CLIPS];
    int unsigned model_data [NUM_CLIPS][CLIP_DEPTH];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_obs();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        rd_addr_q.delete(); rd_cyc_q.delete();
        out_val_q.delete(); out_cyc_q.delete();
        done_cyc_q.delete();
    endtask

    task automatic tick(input logic [DATA_W-1:0] d);
        sample_in   = d;
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        step($urandom_range(0, 2));
    endtask

    task automatic check_idle(input string pfx);
        check_eq({pfx, "_recording"}, 32'(recording), 0);
        check_eq({pfx, "_playing"},   32'(playing), 0);
        check_eq({pfx, "_mem_en"},    32'(mem_if.mem_en), 0);
        check_eq({pfx, "_mem_wen"},   32'(mem_if.mem_wen), 0);
        check_eq({pfx, "_mem_addr"},  32'(mem_if.mem_addr), 0);
        check_eq({pfx, "_mem_wdata"}, 32'(mem_if.mem_wdata), 0);
        check_eq({pfx, "_out"},       32'(sample_out), 0);
        check_eq({pfx, "_out_valid"}, 32'(sample_out_valid), 0);
        check_eq({pfx, "_active"},    32'(active_clip), 0);
        check_eq({pfx, "_done"},      32'(done), 0);
    endtask

    task automatic run_record(input int clip, input int n, input bit also_play,
                              input bit fixed, input int base);
        int unsigned tcyc[$];
        int unsigned dat[$];
        int unsigned rel_cyc, exp_done;
        int nw, bad;
        clear_obs();
        clip_sel_record = SEL_W'(clip);
        clip_sel_play   = SEL_W'($urandom_range(0, NUM_CLIPS-1));
        record = 1'b1;
        if (also_play) play = 1'b1;
        step(1);
        play = 1'b0;
        check_eq("rec_start", 32'(recording), 1);
        check_eq("rec_not_play", 32'(playing), 0);
        check_eq("rec_clip", 32'(active_clip), clip);
        for (int i = 0; i < n; i++) begin
            logic [DATA_W-1:0] d;
            d = fixed ? DATA_W'(base + i) : DATA_W'($urandom);
            dat.push_back(int'(d));
            tcyc.push_back(cyc);
            tick(d);
        end
        if (n > CLIP_DEPTH) check_eq("rec_full_hold", 32'(recording), 1);
        rel_cyc = cyc;
        record  = 1'b0;
        step(3);
        check_eq("rec_end_idle", 32'(recording), 0);
        nw = (n < CLIP_DEPTH) ? n : CLIP_DEPTH;
        check_eq("wr_count", wr_addr_q.size(), nw);
        if (wr_addr_q.size() == nw) begin
            bad = 0;
            for (int i = 0; i < nw; i++) begin
                if (nw <= 16) begin
                    check_eq("wr_addr", wr_addr_q[i], clip*CLIP_DEPTH + i);
                    check_eq("wr_data", wr_data_q[i], dat[i]);
                    check_eq("wr_cyc",  wr_cyc_q[i],  tcyc[i] + 1);
                end else if (wr_addr_q[i] != clip*CLIP_DEPTH + i || wr_data_q[i] != dat[i]
                             || wr_cyc_q[i] != tcyc[i] + 1) begin
                    bad++;
                end
            end
            if (nw > 16) begin
                check_eq("wr_bad_entries", bad, 0);
                check_eq("wr_last_addr", wr_addr_q[nw-1], clip*CLIP_DEPTH + CLIP_DEPTH - 1);
            end
        end
        exp_done = (n >= CLIP_DEPTH) ? tcyc[CLIP_DEPTH-1] + 1 : rel_cyc + 1;
        check_eq("rec_done_count", done_cyc_q.size(), 1);
        if (done_cyc_q.size() == 1) check_eq("rec_done_cyc", done_cyc_q[0], exp_done);
        model_len[clip] = nw;
        for (int i = 0; i < nw; i++) model_data[clip][i] = dat[i];
    endtask

    task automatic run_play(input int clip, input bit loop, input int nticks);
        int unsigned tcyc[$];
        int unsigned len, stop_cyc;
        int nreads, bad;
        bit started, still;
        clear_obs();
        len     = model_len[clip];
        started = (len != 0);
        nreads  = !started ? 0 : (loop ? nticks : ((nticks < int'(len)) ? nticks : int'(len)));
        still   = started && (loop || nticks < int'(len));
        clip_sel_play   = SEL_W'(clip);
        clip_sel_record = SEL_W'($urandom_range(0, NUM_CLIPS-1));
        loop_en = loop;
        play    = 1'b1;
        step(1);
        play = 1'b0;
        check_eq("play_start", 32'(playing), 32'(started));
        if (started) check_eq("play_clip", 32'(active_clip), clip);
        for (int i = 0; i < nticks; i++) begin
            tcyc.push_back(cyc);
            tick(DATA_W'($urandom));
        end
        check_eq("play_busy", 32'(playing), 32'(still));
        if (still) begin
            check_eq("play_no_done_yet", done_cyc_q.size(), 0);
            stop_cyc = cyc;
            play = 1'b1;
            step(1);
            play = 1'b0;
        end
        step(4);
        loop_en = 1'b0;
        check_eq("play_end_idle", 32'(playing), 0);
        check_eq("rd_count", rd_addr_q.size(), nreads);
        check_eq("out_count", out_val_q.size(), nreads);
        if (rd_addr_q.size() == nreads && out_val_q.size() == nreads) begin
            bad = 0;
            for (int k = 0; k < nreads; k++) begin
                int unsigned off;
                off = k % len;
                if (nreads <= 16) begin
                    check_eq("rd_addr", rd_addr_q[k], clip*CLIP_DEPTH + off);
                    check_eq("rd_cyc",  rd_cyc_q[k],  tcyc[k] + 1);
                    check_eq("out_val", out_val_q[k], model_data[clip][off]);
                    check_eq("out_cyc", out_cyc_q[k], tcyc[k] + 2);
                end else if (rd_addr_q[k] != clip*CLIP_DEPTH + off || out_val_q[k] != model_data[clip][off]
                             || out_cyc_q[k] != tcyc[k] + 2) begin
                    bad++;
                end
            end
            if (nreads > 16) check_eq("play_bad_entries", bad, 0);
        end
        check_eq("play_done_count", done_cyc_q.size(), started ? 1 : 0);
        if (started && done_cyc_q.size() == 1)
            check_eq("play_done_cyc", done_cyc_q[0], still ? stop_cyc + 1 : tcyc[len-1] + 2);
    endtask

    task automatic reset_mid(input bit in_play);
        if (in_play) begin
            clip_sel_play = '0;
            loop_en = 1'b1;
            play    = 1'b1;
            step(1);
            play = 1'b0;
            check_eq("rstp_playing", 32'(playing), 1);
        end else begin
            clip_sel_record = 1'b1;
            record = 1'b1;
            step(1);
            check_eq("rstr_recording", 32'(recording), 1);
        end
        for (int i = 0; i < 3; i++) tick(DATA_W'($urandom));
        clear_obs();
        reset  = 1'b0;
        record = 1'b0;
        step(1);
        check_idle(in_play ? "rstp" : "rstr");
        reset   = 1'b1;
        loop_en = 1'b0;
        step(3);
        check_eq("rst_no_done", done_cyc_q.size(), 0);
        for (int c = 0; c < NUM_CLIPS; c++) model_len[c] = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1);
    end

    initial begin
        reset = 1'b0; record = 1'b0; play = 1'b0; loop_en = 1'b0;
        sample_tick = 1'b0; sample_in = '0;
        clip_sel_record = '0; clip_sel_play = '0;
        for (int c = 0; c < NUM_CLIPS; c++) model_len[c] = 0;
        step(3);
        check_idle("por");
        reset = 1'b1;
        step(2);

        run_record(1, 5, 1'b0, 1'b0, 0);
        run_play(0, 1'b0, 3);                 // empty clip: ignored
        run_record(0, 3, 1'b0, 1'b1, 10);
        run_play(0, 1'b0, 3);
        run_play(0, 1'b1, 7);
        run_play(1, 1'b0, 2);                 // stopped by play edge mid-clip
        run_record(1, 4, 1'b1, 1'b0, 0);      // simultaneous edges: record wins
        run_record(1, CLIP_DEPTH + 3, 1'b0, 1'b0, 0);
        run_play(1, 1'b0, 3);
        run_record(1, 2, 1'b0, 1'b0, 0);      // shorter overwrite
        run_play(1, 1'b1, 5);
        reset_mid(1'b1);
        run_play(0, 1'b0, 2);
        run_play(1, 1'b0, 2);
        run_record(0, 3, 1'b0, 1'b0, 0);
        reset_mid(1'b0);
        run_play(0, 1'b0, 2);
        run_play(1, 1'b0, 2);

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 0)
                run_record($urandom_range(0, NUM_CLIPS-1), $urandom_range(0, 12),
                           $urandom_range(0, 3) == 0, 1'b0, 0);
            else
                run_play($urandom_range(0, NUM_CLIPS-1), $urandom_range(0, 1) == 1,
                         $urandom_range(1, 15));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
